// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction-class codes, FSM state encodings and the bus timeout default
package cpu_pkg;
  localparam logic [3:0] FT_WAIT  = 4'b0000;
  localparam logic [3:0] FT_R     = 4'b0001;
  localparam logic [3:0] FT_I     = 4'b0010;
  localparam logic [3:0] FT_LOAD  = 4'b0100;
  localparam logic [3:0] FT_STORE = 4'b0101;
  localparam int MEM_TIMEOUT_DEF = 15;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;
endpackage

// File: rtl/ack_timer.sv
// ack_timer: counts unanswered memory-request cycles and flags when the limit is reached
module ack_timer (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  input  logic [3:0] limit,
  output logic       expired
);
  logic [3:0] cnt;
  // clear wins over increment; the owner clears on every state entry and on timeout
  always_ff @(posedge clk)
    cnt <= clr ? 4'd0 : inc ? cnt + 4'd1 : cnt;
  assign expired = cnt == limit;
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle CPU control sequencer (FETCH/DECODE/EXEC/MEM/WB); INSTR_COUNT_EN adds a retired-instruction counter
module control_fsm
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [3:0]  flag_type,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        flags_we,
  output logic        illegal_op,
  output logic        bus_err,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);
  state_t st, nxt;
  logic [3:0] kind;
  logic expired;
  // strobes react to mem_ack in the same cycle, so they decode state and inputs directly; reset forces them low
  always_comb begin
    nxt = st;
    mem_req = 1'b0;
    mem_we = 1'b0;
    addr_sel = 1'b0;
    ir_load = 1'b0;
    pc_inc = 1'b0;
    alu_src_imm = 1'b0;
    reg_we = 1'b0;
    wb_sel = 1'b0;
    flags_we = 1'b0;
    illegal_op = 1'b0;
    bus_err = 1'b0;
    if (!reset)
      case (st)
        FETCH: if (run) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_load = 1'b1;
            pc_inc = 1'b1;
            nxt = DECODE;
          end else if (expired) bus_err = 1'b1;
        end
        DECODE: begin
          nxt = (flag_type == FT_R || flag_type == FT_I) ? EXEC :
                (flag_type == FT_LOAD || flag_type == FT_STORE) ? MEM : FETCH;
          illegal_op = !(flag_type inside {FT_WAIT, FT_R, FT_I, FT_LOAD, FT_STORE});
        end
        EXEC: begin
          reg_we = 1'b1;
          flags_we = 1'b1;
          alu_src_imm = kind == FT_I;
          nxt = FETCH;
        end
        MEM: begin
          mem_req = 1'b1;
          addr_sel = 1'b1;
          mem_we = kind == FT_STORE;
          if (mem_ack) nxt = (kind == FT_STORE) ? FETCH : WB;
          else if (expired) begin
            bus_err = 1'b1;
            nxt = FETCH;
          end
        end
        WB: begin
          reg_we = 1'b1;
          wb_sel = 1'b1;
          nxt = FETCH;
        end
        default: nxt = FETCH;
      endcase
  end
  // state register; kind captures the decoded class for EXEC/MEM
  always_ff @(posedge clk)
    if (reset) begin
      st <= FETCH;
      kind <= FT_WAIT;
    end else begin
      st <= nxt;
      if (st == DECODE) kind <= flag_type;
    end
  ack_timer u_timer (
    .clk    (clk),
    .clr    (reset || nxt != st || bus_err),
    .inc    (mem_req && !mem_ack),
    .limit  (4'(MEM_TIMEOUT)),
    .expired(expired)
  );
  assign state = reset ? 3'd0 : st;
`ifdef INSTR_COUNT_EN
  logic retire;
  logic [15:0] cnt;
  assign retire = !reset && (st == EXEC || st == WB ||
                  (st == MEM && mem_ack && kind == FT_STORE) ||
                  (st == DECODE && flag_type == FT_WAIT));
  // retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge clk)
    cnt <= reset ? 16'd0 : cnt + 16'(retire);
  assign instr_count = reset ? 16'd0 : cnt;
`else
  assign instr_count = 16'd0;
`endif
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: table-driven directed check of control_fsm with MEM_TIMEOUT=4
module tb_control_fsm;
  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4;
  localparam logic [10:0] MREQ = 11'h400, MWE = 11'h200, ASEL = 11'h100, IRL = 11'h080,
                          PCI = 11'h040, IMM = 11'h020, RWE = 11'h010, WBS = 11'h008,
                          FWE = 11'h004, ILL = 11'h002, BERR = 11'h001;
  localparam logic [10:0] FT = MREQ | IRL | PCI;
`ifdef INSTR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  typedef struct {
    logic rst, run;
    logic [3:0] ft;
    logic ack;
    logic [2:0] es;
    logic [10:0] eo;
    logic [15:0] ec;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0, mem_ack = 1'b0;
  logic [3:0] flag_type = 4'd0;
  logic mem_req, mem_we, addr_sel, ir_load, pc_inc, alu_src_imm, reg_we, wb_sel, flags_we, illegal_op, bus_err;
  logic [2:0] state;
  logic [15:0] instr_count;
  logic [10:0] outs;
  int total = 0, bad = 0;
  vec_t tbl[$];
  assign outs = {mem_req, mem_we, addr_sel, ir_load, pc_inc, alu_src_imm, reg_we, wb_sel, flags_we, illegal_op, bus_err};
  always #5 clk = ~clk;
  control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .run(run), .flag_type(flag_type), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load), .pc_inc(pc_inc),
    .alu_src_imm(alu_src_imm), .reg_we(reg_we), .wb_sel(wb_sel), .flags_we(flags_we),
    .illegal_op(illegal_op), .bus_err(bus_err), .state(state), .instr_count(instr_count)
  );
  function automatic vec_t mk(logic r, logic ru, logic [3:0] f, logic a, logic [2:0] s, logic [10:0] o, logic [15:0] c);
    vec_t v;
    v.rst = r; v.run = ru; v.ft = f; v.ack = a; v.es = s; v.eo = o; v.ec = c;
    return v;
  endfunction
  task automatic step(input vec_t v, input string name);
    logic [29:0] got, exp;
    @(negedge clk);
    reset = v.rst; run = v.run; flag_type = v.ft; mem_ack = v.ack;
    #1;
    got = {state, outs, instr_count};
    exp = {v.es, v.eo, CNT_EN ? v.ec : 16'd0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got state=%0d outs=%b cnt=%0d, want state=%0d outs=%b cnt=%0d",
               name, got[29:27], got[26:16], got[15:0], exp[29:27], exp[26:16], exp[15:0]);
    end
  endtask
  initial begin
    // reset, idle, ack ignored without a request
    tbl.push_back(mk(1, 0, 4'h0, 0, F, 0, 0));
    tbl.push_back(mk(1, 1, 4'h0, 1, F, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, F, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, F, 0, 0));
    // R-type, ack on first fetch cycle, run dropped mid-flight
    tbl.push_back(mk(0, 1, 4'h0, 1, F, FT, 0));
    tbl.push_back(mk(0, 1, 4'h1, 0, D, 0, 0));
    tbl.push_back(mk(0, 0, 4'h1, 0, E, RWE | FWE, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, F, 0, 1));
    // I-type uses latched kind
    tbl.push_back(mk(0, 1, 4'h0, 1, F, FT, 1));
    tbl.push_back(mk(0, 1, 4'h2, 0, D, 0, 1));
    tbl.push_back(mk(0, 1, 4'h0, 0, E, RWE | FWE | IMM, 1));
    // load, ack on third MEM cycle
    tbl.push_back(mk(0, 1, 4'h0, 1, F, FT, 2));
    tbl.push_back(mk(0, 1, 4'h4, 0, D, 0, 2));
    tbl.push_back(mk(0, 1, 4'h0, 0, M, MREQ | ASEL, 2));
    tbl.push_back(mk(0, 1, 4'h0, 0, M, MREQ | ASEL, 2));
    tbl.push_back(mk(0, 1, 4'h0, 1, M, MREQ | ASEL, 2));
    tbl.push_back(mk(0, 1, 4'h0, 0, W, RWE | WBS, 2));
    // store, no WB
    tbl.push_back(mk(0, 1, 4'h0, 1, F, FT, 3));
    tbl.push_back(mk(0, 1, 4'h5, 0, D, 0, 3));
    tbl.push_back(mk(0, 1, 4'h0, 1, M, MREQ | MWE | ASEL, 3));
    tbl.push_back(mk(0, 0, 4'h0, 0, F, 0, 4));
    // illegal class
    tbl.push_back(mk(0, 1, 4'h0, 1, F, FT, 4));
    tbl.push_back(mk(0, 1, 4'hF, 0, D, ILL, 4));
    tbl.push_back(mk(0, 0, 4'h0, 0, F, 0, 4));
    // wait retires in DECODE
    tbl.push_back(mk(0, 1, 4'h0, 1, F, FT, 4));
    tbl.push_back(mk(0, 1, 4'h0, 0, D, 0, 4));
    tbl.push_back(mk(0, 0, 4'h0, 0, F, 0, 5));
    // load timeout: bus_err on fifth MEM cycle, no WB, no retire
    tbl.push_back(mk(0, 1, 4'h0, 1, F, FT, 5));
    tbl.push_back(mk(0, 1, 4'h4, 0, D, 0, 5));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 4'h0, 0, M, MREQ | ASEL, 5));
    tbl.push_back(mk(0, 1, 4'h0, 0, M, MREQ | ASEL | BERR, 5));
    tbl.push_back(mk(0, 0, 4'h0, 0, F, 0, 5));
    // reset during a store wait
    tbl.push_back(mk(0, 1, 4'h0, 1, F, FT, 5));
    tbl.push_back(mk(0, 1, 4'h5, 0, D, 0, 5));
    tbl.push_back(mk(0, 1, 4'h0, 0, M, MREQ | MWE | ASEL, 5));
    tbl.push_back(mk(1, 1, 4'h0, 0, F, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, F, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, F, 0, 0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));
    // fetch timeout retries without pc_inc, then counter restarts
    for (int i = 0; i < 4; i++) step(mk(0, 1, 4'h0, 0, F, MREQ, 0), $sformatf("fto_wait%0d", i));
    step(mk(0, 1, 4'h0, 0, F, MREQ | BERR, 0), "fto_err");
    // ack coinciding with the timeout wins
    for (int i = 0; i < 4; i++) step(mk(0, 1, 4'h0, 0, F, MREQ, 0), $sformatf("race_wait%0d", i));
    step(mk(0, 1, 4'h0, 1, F, FT, 0), "race_ack");
    step(mk(0, 1, 4'h0, 0, D, 0, 0), "race_decode");
    step(mk(0, 0, 4'h0, 0, F, 0, 1), "race_retire");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
